// File: rtl/pcim_rd_arbiter.sv
// Round-robin arbiter sharing the PCIM AXI4 read master (AR/R) among NUM_REQ requesters.
// Bursts are tagged with the requester index on arid; R beats are routed back by rid.
module pcim_rd_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 512,
   parameter int ID_W    = 16,
   parameter int MAX_OUT = 8
) (
   input  logic                      clk_main_a0,
   input  logic                      rst_main_n,
   input  logic [NUM_REQ-1:0]        req_arvalid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
   input  logic [NUM_REQ*8-1:0]      req_arlen,
   output logic [NUM_REQ-1:0]        req_arready,
   output logic [NUM_REQ-1:0]        rsp_rvalid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic [1:0]                rsp_rresp,
   output logic                      rsp_rlast,
   input  logic [NUM_REQ-1:0]        rsp_rready,
   output logic                      pcim_arvalid,
   output logic [ADDR_W-1:0]         pcim_araddr,
   output logic [ID_W-1:0]           pcim_arid,
   output logic [7:0]                pcim_arlen,
   output logic [2:0]                pcim_arsize,
   input  logic                      pcim_arready,
   input  logic                      pcim_rvalid,
   input  logic [DATA_W-1:0]         pcim_rdata,
   input  logic [ID_W-1:0]           pcim_rid,
   input  logic [1:0]                pcim_rresp,
   input  logic                      pcim_rlast,
   output logic                      pcim_rready,
   output logic [NUM_REQ*8-1:0]      out_cnt,
   output logic                      err_bad_rid
);

   // Handshake rule: a transfer happens on a rising edge where valid and ready are both 1;
   // valid never depends on ready, and AR payload is held stable while pcim_arvalid is 1.

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [IDX_W:0]  NUM_REQ_W  = (IDX_W+1)'(NUM_REQ);
   localparam logic [ID_W-1:0] NUM_REQ_ID = ID_W'(NUM_REQ);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     ptr_q;
   logic [IDX_W-1:0]     grant;
   logic                 grant_vld;
   logic                 grant_fire;
   logic [NUM_REQ-1:0]   eligible;
   logic [IDX_W:0]       sum_c;
   logic [ADDR_W-1:0]    sel_addr;
   logic [7:0]           sel_len;
   logic [7:0]           cnt_q [NUM_REQ];
   logic                 rid_ok;
   logic [IDX_W-1:0]     rid_idx;
   logic                 r_done;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++)
         eligible[i] = req_arvalid[i] && (cnt_q[i] < 8'(MAX_OUT));
   end

   // Search starts one past the last grant so the most recent winner has lowest priority.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      sum_c     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         sum_c = {1'b0, ptr_q} + (IDX_W+1)'(k);
         if (sum_c >= NUM_REQ_W) sum_c = sum_c - NUM_REQ_W;
         if (!grant_vld && eligible[sum_c[IDX_W-1:0]]) begin
            grant     = sum_c[IDX_W-1:0];
            grant_vld = 1'b1;
         end
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_len  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant == IDX_W'(i)) begin
            sel_addr = req_araddr[i*ADDR_W +: ADDR_W];
            sel_len  = req_arlen[i*8 +: 8];
         end
      end
   end

   assign grant_fire = (state_q == IDLE) && grant_vld;

   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) state_q <= IDLE;
      else             state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_vld) state_d = ISSUE;
         ISSUE:   if (pcim_arready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_arready = '0;
      if (state_q == IDLE && grant_vld && rst_main_n) req_arready[grant] = 1'b1;
   end

   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         pcim_arvalid <= 1'b0;
         pcim_araddr  <= '0;
         pcim_arid    <= '0;
         pcim_arlen   <= '0;
         ptr_q        <= IDX_W'(NUM_REQ - 1);
      end else if (grant_fire) begin
         pcim_arvalid <= 1'b1;
         pcim_araddr  <= sel_addr;
         pcim_arid    <= ID_W'(grant);
         pcim_arlen   <= sel_len;
         ptr_q        <= grant;
      end else if (state_q == ISSUE && pcim_arready) begin
         pcim_arvalid <= 1'b0;
      end
   end

   assign pcim_arsize = 3'd6;

   // Out-of-range rids are always accepted so a stray beat cannot wedge the R channel.
   assign rid_ok  = pcim_rid < NUM_REQ_ID;
   assign rid_idx = pcim_rid[IDX_W-1:0];

   always_comb begin
      rsp_rvalid  = '0;
      pcim_rready = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rid_ok && rid_idx == IDX_W'(i)) begin
            rsp_rvalid[i] = pcim_rvalid;
            pcim_rready   = rsp_rready[i];
         end
      end
   end

   assign rsp_rdata = pcim_rdata;
   assign rsp_rresp = pcim_rresp;
   assign rsp_rlast = pcim_rlast;
   assign r_done    = pcim_rvalid && pcim_rready && pcim_rlast && rid_ok;

   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_fire && grant == IDX_W'(i) && !(r_done && rid_idx == IDX_W'(i)))
               cnt_q[i] <= cnt_q[i] + 8'd1;
            else if (r_done && rid_idx == IDX_W'(i) && !(grant_fire && grant == IDX_W'(i))
                     && cnt_q[i] != 8'd0)
               cnt_q[i] <= cnt_q[i] - 8'd1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) out_cnt[i*8 +: 8] = cnt_q[i];
   end

   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n)                  err_bad_rid <= 1'b0;
      else if (pcim_rvalid && !rid_ok)  err_bad_rid <= 1'b1;
   end

endmodule

// File: tb/tb_pcim_rd_arbiter.sv
// Directed and randomized bench for pcim_rd_arbiter against a cycle-level behavioural model.
module tb_pcim_rd_arbiter;
   localparam int NR = 4;
   localparam int AW = 64;
   localparam int DW = 512;
   localparam int IW = 16;
   localparam int MO = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     req_arvalid;
   logic [NR*AW-1:0]  req_araddr;
   logic [NR*8-1:0]   req_arlen;
   logic [NR-1:0]     req_arready;
   logic [NR-1:0]     rsp_rvalid;
   logic [DW-1:0]     rsp_rdata;
   logic [1:0]        rsp_rresp;
   logic              rsp_rlast;
   logic [NR-1:0]     rsp_rready;
   logic              pcim_arvalid;
   logic [AW-1:0]     pcim_araddr;
   logic [IW-1:0]     pcim_arid;
   logic [7:0]        pcim_arlen;
   logic [2:0]        pcim_arsize;
   logic              pcim_arready;
   logic              pcim_rvalid;
   logic [DW-1:0]     pcim_rdata;
   logic [IW-1:0]     pcim_rid;
   logic [1:0]        pcim_rresp;
   logic              pcim_rlast;
   logic              pcim_rready;
   logic [NR*8-1:0]   out_cnt;
   logic              err_bad_rid;

   pcim_rd_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MAX_OUT(MO)) dut (
      .clk_main_a0(clk), .rst_main_n(rst_n),
      .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
      .req_arready(req_arready),
      .rsp_rvalid(rsp_rvalid), .rsp_rdata(rsp_rdata), .rsp_rresp(rsp_rresp),
      .rsp_rlast(rsp_rlast), .rsp_rready(rsp_rready),
      .pcim_arvalid(pcim_arvalid), .pcim_araddr(pcim_araddr), .pcim_arid(pcim_arid),
      .pcim_arlen(pcim_arlen), .pcim_arsize(pcim_arsize), .pcim_arready(pcim_arready),
      .pcim_rvalid(pcim_rvalid), .pcim_rdata(pcim_rdata), .pcim_rid(pcim_rid),
      .pcim_rresp(pcim_rresp), .pcim_rlast(pcim_rlast), .pcim_rready(pcim_rready),
      .out_cnt(out_cnt), .err_bad_rid(err_bad_rid)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // behavioural model state
   bit          m_busy;
   int          m_ptr;
   int          m_cnt [NR];
   bit          m_err;
   logic [63:0] m_addr;
   logic [7:0]  m_len;
   int          m_id;
   int          m_grant;
   logic [NR-1:0] m_arready;
   logic [NR-1:0] m_rvalid;
   logic        m_rready;

   // observation bookkeeping
   int obs_gcnt [NR];
   int obs_total;
   int obs_rvcnt [NR];
   int cyc;
   int g_log[$];
   int g_cyc[$];

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      req_arvalid  = '0;
      req_araddr   = '0;
      req_arlen    = '0;
      rsp_rready   = '0;
      pcim_arready = 1'b0;
      pcim_rvalid  = 1'b0;
      pcim_rdata   = '0;
      pcim_rid     = '0;
      pcim_rresp   = '0;
      pcim_rlast   = 1'b0;
   endtask

   task automatic model_reset();
      m_busy = 0; m_ptr = NR - 1; m_err = 0;
      m_addr = '0; m_len = '0; m_id = 0;
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
   endtask

   task automatic clear_obs();
      obs_total = 0;
      for (int i = 0; i < NR; i++) begin obs_gcnt[i] = 0; obs_rvcnt[i] = 0; end
      g_log.delete();
      g_cyc.delete();
   endtask

   // Expected combinational outputs from the current inputs and model state.
   task automatic model_comb();
      int idx;
      m_grant = -1;
      if (!m_busy) begin
         for (int k = 1; k <= NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (m_grant < 0 && req_arvalid[idx] && m_cnt[idx] < MO) m_grant = idx;
         end
      end
      m_arready = (m_grant >= 0) ? NR'(1 << m_grant) : '0;
      if (pcim_rid < NR) begin
         m_rvalid = pcim_rvalid ? NR'(1 << pcim_rid) : '0;
         m_rready = rsp_rready[pcim_rid];
      end else begin
         m_rvalid = '0;
         m_rready = 1'b1;
      end
   endtask

   task automatic model_edge();
      bit dec;
      dec = pcim_rvalid && m_rready && pcim_rlast && (pcim_rid < NR);
      if (m_grant >= 0) begin
         m_busy = 1;
         m_addr = req_araddr[m_grant*AW +: AW];
         m_len  = req_arlen[m_grant*8 +: 8];
         m_id   = m_grant;
         m_ptr  = m_grant;
         m_cnt[m_grant]++;
      end else if (m_busy && pcim_arready) begin
         m_busy = 0;
      end
      if (dec && m_cnt[pcim_rid] > 0) m_cnt[pcim_rid]--;
      if (pcim_rvalid && pcim_rid >= NR) m_err = 1;
   endtask

   task automatic check_regs(input string pfx);
      chk({pfx, "_arvalid"}, pcim_arvalid, m_busy);
      chk({pfx, "_araddr"}, pcim_araddr, m_addr);
      chk({pfx, "_arid"}, pcim_arid, IW'(m_id));
      chk({pfx, "_arlen"}, pcim_arlen, m_len);
      chk({pfx, "_arsize"}, pcim_arsize, 3'd6);
      for (int i = 0; i < NR; i++) chk({pfx, "_out_cnt"}, out_cnt[i*8 +: 8], 8'(m_cnt[i]));
      chk({pfx, "_err_bad_rid"}, err_bad_rid, m_err);
   endtask

   // Entered at posedge+1 with inputs applied; returns at the next posedge+1.
   task automatic cycle();
      #1;
      model_comb();
      chk("req_arready", req_arready, m_arready);
      chk("rsp_rvalid", rsp_rvalid, m_rvalid);
      chk("pcim_rready", pcim_rready, m_rready);
      chk("rsp_rdata", rsp_rdata, pcim_rdata);
      chk("rsp_rresp", rsp_rresp, pcim_rresp);
      chk("rsp_rlast", rsp_rlast, pcim_rlast);
      for (int i = 0; i < NR; i++) begin
         if (req_arready[i]) begin
            obs_gcnt[i]++; obs_total++; g_log.push_back(i); g_cyc.push_back(cyc);
         end
         if (rsp_rvalid[i]) obs_rvcnt[i]++;
      end
      @(posedge clk);
      model_edge();
      #1;
      check_regs("reg");
      cyc++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      req_arvalid = '1;
      #1;
      chk("rst_arready", req_arready, '0);
      check_regs("rst");
      req_arvalid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      clear_obs();
   endtask

   initial begin
      int exp_order [6];
      exp_order = '{0, 1, 2, 3, 0, 1};
      cyc = 0;

      // single burst from requester 2
      do_reset();
      req_arvalid = 4'b0100;
      req_araddr[2*AW +: AW] = 64'h1000;
      req_arlen[2*8 +: 8] = 8'd3;
      cycle();
      chk("t1_grants", obs_gcnt[2], 1);
      chk("t1_arid", pcim_arid, 16'd2);
      chk("t1_cnt_up", out_cnt[2*8 +: 8], 8'd1);
      req_arvalid = '0;
      pcim_arready = 1'b1;
      cycle();
      pcim_arready = 1'b0;
      rsp_rready = 4'b0100;
      for (int b = 0; b < 4; b++) begin
         pcim_rvalid = 1'b1;
         pcim_rid = 16'd2;
         pcim_rlast = (b == 3);
         for (int j = 0; j < DW/32; j++) pcim_rdata[j*32 +: 32] = $urandom;
         cycle();
      end
      pcim_rvalid = 1'b0; pcim_rlast = 1'b0;
      chk("t1_pulses", obs_rvcnt[2], 4);
      chk("t1_cnt_down", out_cnt[2*8 +: 8], 8'd0);

      // all requesters, round-robin order and grant spacing
      do_reset();
      req_arvalid = 4'b1111;
      pcim_arready = 1'b1;
      repeat (12) cycle();
      chk("t2_ngrants", g_log.size(), 6);
      for (int i = 0; i < 6 && i < g_log.size(); i++) chk("t2_order", g_log[i], exp_order[i]);
      for (int i = 1; i < g_cyc.size(); i++) chk("t2_spacing", g_cyc[i] - g_cyc[i-1], 2);

      // credit exhaustion on requester 1
      do_reset();
      req_arvalid = 4'b0010;
      pcim_arready = 1'b1;
      repeat (20) cycle();
      chk("t3_fill", obs_gcnt[1], MO);
      chk("t3_cnt_max", out_cnt[1*8 +: 8], 8'(MO));
      clear_obs();
      req_arvalid = 4'b1111;
      repeat (10) cycle();
      chk("t3_starved", obs_gcnt[1], 0);
      chk("t3_others", obs_total, 5);
      clear_obs();
      req_arvalid = 4'b0010;
      pcim_rvalid = 1'b1; pcim_rid = 16'd1; pcim_rlast = 1'b1; rsp_rready = 4'b0010;
      cycle();
      pcim_rvalid = 1'b0; pcim_rlast = 1'b0;
      repeat (9) cycle();
      chk("t3_one_more", obs_gcnt[1], 1);
      chk("t3_cnt_refill", out_cnt[1*8 +: 8], 8'(MO));

      // AR stall in ISSUE
      do_reset();
      req_arvalid = 4'b0001;
      req_araddr[0 +: AW] = {$urandom, $urandom};
      req_arlen[0 +: 8] = 8'(($urandom_range(0, 255)));
      pcim_arready = 1'b0;
      cycle();
      clear_obs();
      req_arvalid = 4'b1111;
      repeat (5) cycle();
      chk("t4_no_grant", obs_total, 0);
      chk("t4_held", pcim_arvalid, 1'b1);
      pcim_arready = 1'b1;
      cycle();
      chk("t4_accept_cycle", obs_total, 0);
      cycle();
      chk("t4_next_grant", obs_total, 1);
      chk("t4_next_idx", obs_gcnt[1], 1);

      // simultaneous grant and completion on requester 0
      do_reset();
      req_arvalid = 4'b0001;
      pcim_arready = 1'b1;
      repeat (6) cycle();
      chk("t5_cnt_pre", out_cnt[0 +: 8], 8'd3);
      clear_obs();
      pcim_rvalid = 1'b1; pcim_rid = 16'd0; pcim_rlast = 1'b1; rsp_rready = 4'b0001;
      cycle();
      chk("t5_grant", obs_gcnt[0], 1);
      chk("t5_cnt_same", out_cnt[0 +: 8], 8'd3);
      pcim_rvalid = 1'b0; pcim_rlast = 1'b0;

      // bad rid, sticky error, async reset mid-ISSUE
      do_reset();
      pcim_rvalid = 1'b1; pcim_rid = 16'd7; rsp_rready = '0;
      cycle();
      chk("t6_err_set", err_bad_rid, 1'b1);
      pcim_rvalid = 1'b0;
      repeat (3) cycle();
      chk("t6_err_sticky", err_bad_rid, 1'b1);
      req_arvalid = 4'b0100;
      pcim_arready = 1'b0;
      cycle();
      req_arvalid = '0;
      cycle();
      chk("t6_issue", pcim_arvalid, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_async_arvalid", pcim_arvalid, 1'b0);
      chk("t6_async_cnt", out_cnt, '0);
      chk("t6_async_err", err_bad_rid, 1'b0);

      // randomized traffic
      do_reset();
      repeat (400) begin
         req_arvalid = NR'($urandom);
         for (int i = 0; i < NR; i++) begin
            req_araddr[i*AW +: AW] = {$urandom, $urandom};
            req_arlen[i*8 +: 8] = 8'($urandom_range(0, 255));
         end
         pcim_arready = ($urandom_range(0, 3) != 0);
         pcim_rvalid = $urandom_range(0, 1);
         pcim_rid = ($urandom_range(0, 31) == 0) ? IW'($urandom_range(NR, 65535))
                                                   : IW'($urandom_range(0, NR - 1));
         pcim_rlast = $urandom_range(0, 1);
         pcim_rresp = 2'($urandom_range(0, 3));
         rsp_rready = NR'($urandom);
         for (int j = 0; j < DW/32; j++) pcim_rdata[j*32 +: 32] = $urandom;
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/pcim_rd_arbiter.md
Name: pcim_rd_arbiter

Overview:
- Shares the single PCIM AXI4 read master (AR and R channels toward the shell) among NUM_REQ internal read requesters.
- Round-robin arbitration on AR.
- Tags each burst's arid with the requester index and routes R beats back by rid.
- Enforces a per-requester outstanding-burst credit limit.
- Sits between the portal/DMA read engines inside mkAwsF1Top and the cl_sh_pcim_ar*/sh_cl_pcim_r* pins.

Parameters:
- NUM_REQ, 4: number of requesters (2..16).
- ADDR_W, 64: PCIM address width.
- DATA_W, 512: PCIM read data width.
- ID_W, 16: PCIM arid/rid width.
- MAX_OUT, 8: maximum outstanding bursts per requester (1..255).

Ports:
- clk_main_a0  in  1  main clock; all logic synchronous to it
- rst_main_n  in  1  asynchronous, active-low reset
- req_arvalid  in  NUM_REQ  per-requester read request valid
- req_araddr  in  NUM_REQ*ADDR_W  per-requester address, requester i at slice i
- req_arlen  in  NUM_REQ*8  per-requester burst length minus 1
- req_arready  out  NUM_REQ  per-requester request accept
- rsp_rvalid  out  NUM_REQ  per-requester read data valid
- rsp_rdata  out  DATA_W  shared read data
- rsp_rresp  out  2  shared read response
- rsp_rlast  out  1  shared last beat
- rsp_rready  in  NUM_REQ  per-requester read data ready
- pcim_arvalid  out  1  AR valid to shell
- pcim_araddr  out  ADDR_W  AR address
- pcim_arid  out  ID_W  AR id
- pcim_arlen  out  8  AR length
- pcim_arsize  out  3  AR size; constant 3'd6
- pcim_arready  in  1  AR ready from shell
- pcim_rvalid  in  1  R valid from shell
- pcim_rdata  in  DATA_W  R data
- pcim_rid  in  ID_W  R id
- pcim_rresp  in  2  R response
- pcim_rlast  in  1  R last
- pcim_rready  out  1  R ready to shell
- out_cnt  out  NUM_REQ*8  per-requester outstanding-burst count
- err_bad_rid  out  1  sticky: R beat received with rid >= NUM_REQ

Behaviour:
- Reset (async assert, sync deassert use):
  - AR FSM to IDLE; pcim_arvalid=0; pcim_araddr/arid/arlen=0.
  - Round-robin pointer=NUM_REQ-1, so requester 0 has first priority.
  - All out_cnt=0; err_bad_rid=0; req_arready=0.
- AR FSM, IDLE:
  - eligible[i] = req_arvalid[i] & (out_cnt[i] < MAX_OUT).
  - If any eligible: grant the first eligible index strictly after the pointer, wrapping modulo NUM_REQ.
  - req_arready[grant]=1 combinationally in this cycle; all other req_arready=0.
  - On the clock edge: capture araddr/arlen into output registers; arid = zero-extended grant index; pointer=grant; pcim_arvalid=1; go ISSUE.
  - If none eligible, stay in IDLE.
- AR FSM, ISSUE:
  - pcim_arvalid=1; address, id and length held stable; all req_arready=0.
  - On pcim_arready=1: pcim_arvalid=0 next cycle; go IDLE.
  - Peak rate is one burst per 2 cycles.
- Credit counting:
  - out_cnt[g] increments on the grant edge (IDLE with a grant).
  - out_cnt[r] decrements on an R handshake (pcim_rvalid & pcim_rready) with pcim_rlast=1 and rid=r<NUM_REQ.
  - Simultaneous increment and decrement on the same requester: count unchanged.
  - Decrement at 0 saturates at 0; this covers stale responses after reset.
  - At MAX_OUT the requester is ineligible and its req_arready stays 0.
- R routing (combinational, zero latency):
  - r = pcim_rid[log2(NUM_REQ)-1:0] when rid < NUM_REQ.
  - rsp_rvalid[r] = pcim_rvalid; all other rsp_rvalid=0.
  - pcim_rready = rsp_rready[r].
  - rsp_rdata/rresp/rlast = pcim_rdata/rresp/rlast, passed through unconditionally.
- Bad rid (rid >= NUM_REQ):
  - pcim_rready=1 (beat dropped); all rsp_rvalid=0.
  - err_bad_rid set on pcim_rvalid; cleared only by reset.
- No pcim_rvalid → pcim_rready is don't-care; it is driven as rsp_rready of the index decoded from rid.
- Reset mid-ISSUE: pcim_arvalid drops immediately. The shell-side protocol violation is accepted because the shell is reset in the same domain.

Test Plan:
- Single requester 2 issues arlen=3 addr 0x1000: req_arready[2] high 1 cycle; pcim_arvalid with arid=2, arsize=6; out_cnt[2]=1; after 4 R beats rid=2 with rlast on the 4th, rsp_rvalid[2] pulses 4 times and out_cnt[2]=0.
- All 4 requesters valid continuously, pcim_arready=1: grant order 0,1,2,3,0,1,… with one grant every 2 cycles.
- Requester 1 with rsp never returned, MAX_OUT=8: after 8 grants req_arready[1] stays 0 and the other requesters continue. Returning one rlast beat for rid=1 re-enables exactly one further grant.
- pcim_arready held 0 for 5 cycles in ISSUE: araddr/arid/arlen stable, no other req_arready asserted; grant proceeds one cycle after arready.
- Same-cycle grant to requester 0 and rlast handshake for rid=0 with out_cnt[0]=3: out_cnt[0] stays 3.
- R beat with rid=7 (NUM_REQ=4): pcim_rready=1, no rsp_rvalid, err_bad_rid=1 until rst_main_n asserted; async reset mid-ISSUE clears pcim_arvalid and out_cnt without a clock edge.
